// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM encoding, MAC widths and result clamping for the FC stream feeder.
package fc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int FC_SIZE_W = 14;
    localparam int ACC_W = 32;
    function automatic logic [ACC_W-1:0] relu32(input logic [ACC_W-1:0] v, input logic en);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction
endpackage

// File: rtl/fc_stream_feeder_if.sv
// fc_stream_feeder_if: control, buffer and MAC signals between the feeder (master) and its environment.
interface fc_stream_feeder_if #(
    parameter int DW = 16,
    parameter int IN_AW = 14,
    parameter int W_AW = 24,
    parameter int OUT_AW = 12
) ();
    import fc_pkg::*;
    logic                 start;
    logic [IN_AW-1:0]     num_inputs;
    logic [OUT_AW-1:0]    num_outputs;
    logic                 busy;
    logic                 done;
    logic                 x_rd;
    logic [IN_AW-1:0]     x_addr;
    logic [DW-1:0]        x_rdata;
    logic                 w_rd;
    logic [W_AW-1:0]      w_addr;
    logic [DW-1:0]        w_rdata;
    logic [OUT_AW-1:0]    b_addr;
    logic [DW-1:0]        b_rdata;
    logic                 fc_en;
    logic [DW-1:0]        fc_din;
    logic [DW-1:0]        fc_weight;
    logic [DW-1:0]        fc_bias;
    logic [FC_SIZE_W-1:0] fc_size;
    logic [ACC_W-1:0]     fc_out;
    logic                 fc_ack;
    logic                 res_we;
    logic [OUT_AW-1:0]    res_addr;
    logic [ACC_W-1:0]     res_data;
    modport master (
        input  start, num_inputs, num_outputs, x_rdata, w_rdata, b_rdata, fc_out, fc_ack,
        output busy, done, x_rd, x_addr, w_rd, w_addr, b_addr, fc_en, fc_din, fc_weight,
               fc_bias, fc_size, res_we, res_addr, res_data
    );
    modport slave (
        output start, num_inputs, num_outputs, x_rdata, w_rdata, b_rdata, fc_out, fc_ack,
        input  busy, done, x_rd, x_addr, w_rd, w_addr, b_addr, fc_en, fc_din, fc_weight,
               fc_bias, fc_size, res_we, res_addr, res_data
    );
endinterface

// File: rtl/fc_addr_gen.sv
// fc_addr_gen: walks slots k=0..N of each neuron j, producing buffer addresses and read enables.
module fc_addr_gen #(
    parameter int IN_AW = 14,
    parameter int W_AW = 24,
    parameter int OUT_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic [IN_AW-1:0]  n_i,
    input  logic [OUT_AW-1:0] m_i,
    output logic              rd_o,
    output logic              last_o,
    output logic [IN_AW-1:0]  x_addr_o,
    output logic [W_AW-1:0]   w_addr_o,
    output logic [OUT_AW-1:0] b_addr_o
);
    logic [IN_AW-1:0]  k_q, k_d;
    logic [OUT_AW-1:0] j_q, j_d;
    logic [W_AW-1:0]   wbase_q, wbase_d;
    logic              gap;
    always_comb begin
        gap      = k_q == n_i;
        rd_o     = run_i && !gap;
        last_o   = run_i && gap && j_q == m_i - 1'b1;
        k_d      = (!run_i || gap) ? '0 : k_q + 1'b1;
        j_d      = !run_i ? '0 : gap ? j_q + 1'b1 : j_q;
        wbase_d  = !run_i ? '0 : gap ? wbase_q + W_AW'(n_i) : wbase_q;
        x_addr_o = k_q;
        w_addr_o = wbase_q + W_AW'(k_q);
        b_addr_o = j_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            j_q     <= '0;
            wbase_q <= '0;
        end else begin
            k_q     <= k_d;
            j_q     <= j_d;
            wbase_q <= wbase_d;
        end
    end
endmodule

// File: rtl/fc_stream_feeder.sv
// fc_stream_feeder: streams activations/weights/biases into the FC MAC one neuron per frame
// and writes each acknowledged result (optionally ReLU-clamped) to the output buffer.
module fc_stream_feeder
    import fc_pkg::*;
#(
    parameter int DW = 16,
    parameter int IN_AW = 14,
    parameter int W_AW = 24,
    parameter int OUT_AW = 12,
    parameter int RELU = 1
) (
    input logic clk,
    input logic rst,
    fc_stream_feeder_if.master bus_io
);
    state_t               state_q, state_d;
    logic [IN_AW-1:0]     n_q;
    logic [OUT_AW-1:0]    m_q, out_cnt_q, res_addr_q;
    logic [FC_SIZE_W-1:0] size_q;
    logic [ACC_W-1:0]     res_data_q;
    logic                 en_q, real_q, we_q;
    logic                 rd, last, go, zero, cap, fin;
    logic [IN_AW-1:0]     x_addr;
    logic [W_AW-1:0]      w_addr;
    logic [OUT_AW-1:0]    b_addr;

    fc_addr_gen #(.IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)) u_addr_gen (
        .clk(clk), .rst(rst), .run_i(state_q == RUN), .n_i(n_q), .m_i(m_q),
        .rd_o(rd), .last_o(last), .x_addr_o(x_addr), .w_addr_o(w_addr), .b_addr_o(b_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        zero    = bus_io.num_inputs == '0 || bus_io.num_outputs == '0;
        go      = state_q == IDLE && bus_io.start && !zero;
        fin     = we_q && out_cnt_q == m_q;
        state_d = state_q == IDLE  ? (bus_io.start ? (zero ? DONE : RUN) : IDLE) :
                  state_q == RUN   ? (last ? DRAIN : RUN) :
                  state_q == DRAIN ? (fin ? DONE : DRAIN) : IDLE;
    end

    always_comb begin
        bus_io.busy = state_q == RUN || state_q == DRAIN;
        bus_io.done = state_q == DONE;
        cap         = bus_io.fc_ack && (state_q == RUN || state_q == DRAIN);
    end

    // Data stage trails issue by one cycle to match the buffers' read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q        <= '0;
            m_q        <= '0;
            size_q     <= '0;
            en_q       <= 1'b0;
            real_q     <= 1'b0;
            we_q       <= 1'b0;
            out_cnt_q  <= '0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            if (go) begin
                n_q    <= bus_io.num_inputs;
                m_q    <= bus_io.num_outputs;
                size_q <= FC_SIZE_W'(bus_io.num_inputs + 1'b1);
            end
            en_q      <= state_q == RUN;
            real_q    <= rd;
            we_q      <= cap;
            out_cnt_q <= go ? '0 : out_cnt_q + OUT_AW'(cap);
            if (cap) begin
                res_addr_q <= out_cnt_q;
                res_data_q <= relu32(bus_io.fc_out, RELU != 0);
            end
        end
    end

    always_comb begin
        bus_io.x_rd      = rd;
        bus_io.w_rd      = rd;
        bus_io.x_addr    = x_addr;
        bus_io.w_addr    = w_addr;
        bus_io.b_addr    = b_addr;
        bus_io.fc_en     = en_q;
        bus_io.fc_din    = real_q ? bus_io.x_rdata : {DW{1'b0}};
        bus_io.fc_weight = real_q ? bus_io.w_rdata : {DW{1'b0}};
        bus_io.fc_bias   = bus_io.b_rdata;
        bus_io.fc_size   = size_q;
        bus_io.res_we    = we_q;
        bus_io.res_addr  = res_addr_q;
        bus_io.res_data  = res_data_q;
    end
endmodule

// File: doc/fc_stream_feeder.md
Name: fc_stream_feeder

Overview:
- Sequencer and initiator that drives the fully-connected MAC engine (en / D_in / Weight / Bias / Size in, 32-bit result plus fc_ack out).
- Reads activations, weights and biases from synchronous-read buffers and streams one output neuron per MAC frame.
- Captures each neuron result on fc_ack, applies optional ReLU, and writes it to the FC output buffer.
- Sits between the previous layer's activation buffer and the next layer's input buffer.

Parameters:
- DW, 16, activation/weight/bias width.
- IN_AW, 14, activation address width; max num_inputs = 2^IN_AW − 2.
- W_AW, 24, weight address width.
- OUT_AW, 12, output/bias address width.
- RELU, 1, when 1 clamp negative results (bit 31 set) to 0 before writing.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_inputs  in  IN_AW  N, inputs per neuron; latched at start.
- num_outputs  in  OUT_AW  M, neurons; latched at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion.
- x_rd  out  1  activation read enable.
- x_addr  out  IN_AW  activation address.
- x_rdata  in  DW  activation data, valid 1 cycle after x_rd.
- w_rd  out  1  weight read enable.
- w_addr  out  W_AW  weight address, row-major j*N+k.
- w_rdata  in  DW  weight data, 1-cycle latency.
- b_addr  out  OUT_AW  bias address (= j).
- b_rdata  in  DW  bias data, 1-cycle latency.
- fc_en  out  1  MAC enable.
- fc_din  out  DW  MAC D_in.
- fc_weight  out  DW  MAC Weight.
- fc_bias  out  DW  MAC Bias; combinational pass-through of b_rdata.
- fc_size  out  14  MAC Size; latched N+1.
- fc_out  in  32  MAC accumulator.
- fc_ack  in  1  MAC result-valid strobe.
- res_we  out  1  output buffer write strobe.
- res_addr  out  OUT_AW  output index j.
- res_data  out  32  result, ReLU applied per RELU.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0.
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: on start with N≥1 and M≥1, latch N and M, set fc_size=N+1, go to RUN.
- IDLE, N==0 or M==0: go directly to DONE; no reads, no fc_en, no writes.
- MAC frame contract: the MAC accumulates on its first Size−1 enabled cycles, adds Bias on slot Size−2, and asserts fc_ack during slot Size−1 while clearing itself.
  - Each neuron therefore occupies exactly N+1 consecutive issue slots k=0..N.
- RUN issue stage, per slot:
  - k<N: x_rd=w_rd=1, x_addr=k, w_addr=wbase+k.
  - k=N: gap slot, reads off.
  - b_addr=j, updated at slot 0.
  - After k=N: k→0, j→j+1, wbase→wbase+N (adder, no multiplier).
- Data stage (1 cycle behind issue):
  - fc_en=1.
  - fc_din/fc_weight = x_rdata/w_rdata for real slots; 0 for the gap slot.
- fc_en stays high continuously across neuron boundaries within a run; the MAC counter wraps naturally.
- After the last slot of neuron M−1, go to DRAIN:
  - fc_en drops one cycle later.
  - Wait for the final fc_ack.
- Capture: in any cycle with fc_ack=1, on the next edge:
  - res_we=1, res_addr=out_cnt, res_data=RELU&&fc_out[31] ? 0 : fc_out.
  - out_cnt increments.
- res_we is a one-cycle pulse per neuron. Exactly M writes per run, at indices 0..M−1 in order.
- DONE: done=1 for one cycle in the cycle after the final res_we, busy=0, then return to IDLE.
- Latency: first fc_en 2 cycles after start; neuron j result written 1 cycle after its fc_ack; total run M*(N+1)+≈4 cycles.
- start while busy: ignored. num_inputs/num_outputs changes mid-run: ignored (latched values used).
- fc_ack outside a run: ignored, no write.
- rst mid-run: immediate abort; outputs as reset, fc_en=0 clears the MAC; no partial write and no done pulse.
- N=1: 2-slot frames; bias add and ack still occur correctly.

Decomposition:
- Package fc_pkg:
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - FC_SIZE_W=14, ACC_W=32.
  - Function relu32.
- Sub-module fc_addr_gen: k/j/wbase counters and read-enable generation.
- Top level holds the data-stage pipeline, the capture/writeback logic and the FSM.

Test Plan:
1. N=2, M=1, x=[3,4], w=[5,6], b=[7] → fc_size=3, fc_en high 3 cycles, single write addr 0 data 46, done 1 cycle later.
2. N=3, M=2, x=[1,2,3], w=[1,1,1, 2,0,1], b=[10,0] → writes (0,16),(1,5); fc_en continuous for 8 cycles, no gap.
3. RELU=1, MAC model returns 0xFFFF_FFF0 → res_data=0; with RELU=0 → 0xFFFF_FFF0.
4. start with N=0 (M=4) → no x_rd/fc_en/res_we, done pulse 1 cycle later; then start with M=0 → same.
5. N=4, M=3, assert rst after the 2nd write → all outputs 0 next cycle, no 3rd write, no done; a fresh start then yields correct writes 0..2.
6. Second start pulse mid-run, then a spurious fc_ack in IDLE → both ignored; write count stays exactly M.
